// File: rtl/wb_master_seq.sv
// Single-transfer Wishbone classic initiator: one bus cycle per command, response on rsp_*.
// Define WBM_SEQ_ERR_EN to add the wbm_err_i slave error input.
module wb_master_seq #(
    parameter int unsigned         ADDR_W  = 32,
    parameter int unsigned         DATA_W  = 32,
    parameter int unsigned         TIMEOUT = 16,
    parameter logic [DATA_W-1:0]   TO_DATA = 32'hFFFF_FFFF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_adr,
    input  logic [DATA_W-1:0] cmd_dat,
    input  logic [3:0]        cmd_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_dat,
    output logic              rsp_err,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [DATA_W-1:0] wbm_dat_o,
    input  logic              wbm_ack_i,
`ifdef WBM_SEQ_ERR_EN
    input  logic              wbm_err_i,
`endif
    input  logic [DATA_W-1:0] wbm_dat_i
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic                rsp_err_q, rsp_err_d;
    logic                cyc_q, cyc_d;
    logic                stb_q, stb_d;
    logic                we_q, we_d;
    logic [3:0]          sel_q, sel_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                bus_err;
    logic                timeout_hit;

`ifdef WBM_SEQ_ERR_EN
    assign bus_err = wbm_err_i;
`else
    assign bus_err = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    we_d        = cmd_we;
                    sel_d       = cmd_sel;
                    adr_d       = cmd_adr;
                    dat_d       = cmd_dat;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = StBus;
                end
            end
            StBus: begin
                // Priority: slave error, then ack, then timeout.
                if (bus_err || wbm_ack_i || timeout_hit) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                    if (bus_err || !wbm_ack_i) begin
                        rsp_err_d = 1'b1;
                        rsp_dat_d = TO_DATA;
                    end else begin
                        rsp_err_d = 1'b0;
                        rsp_dat_d = we_q ? '0 : wbm_dat_i;
                    end
                end else if (cnt_q != {CntW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_master_seq.sv
// Self-checking bench for wb_master_seq: directed vector table, corner sequences, random traffic.
module tb_wb_master_seq;

    localparam int unsigned TIMEOUT = 16;
    localparam logic [31:0] TO_DATA = 32'hFFFF_FFFF;
    localparam int          NEVER   = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, wbm_err_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_master_seq #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT),
        .TO_DATA(TO_DATA)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i),
`ifdef WBM_SEQ_ERR_EN
        .wbm_err_i(wbm_err_i),
`endif
        .wbm_dat_i(wbm_dat_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          ack_dly;
        logic [31:0] rdata;
        int          rsp_dly;
        int          exp_stb;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference: the slave acks after ack_dly wait states unless TIMEOUT strobe cycles pass first.
    function automatic void model(input logic we, input int ack_dly, input logic [31:0] rdata,
                                  output int stb_n, output logic err, output logic [31:0] dat);
        if (ack_dly < int'(TIMEOUT)) begin
            stb_n = ack_dly + 1;
            err   = 1'b0;
            dat   = we ? 32'h0 : rdata;
        end else begin
            stb_n = int'(TIMEOUT);
            err   = 1'b1;
            dat   = TO_DATA;
        end
    endfunction

    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int ack_dly, input logic [31:0] rdata,
                           input int rsp_dly, output int stb_n, output logic err,
                           output logic [31:0] rdat);
        int n;
        stb_n = 0;
        err   = 1'b0;
        rdat  = 32'h0;
        n     = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", {31'b0, cmd_ready}, 32'h1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_we    = 1'($urandom);
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = 4'($urandom);
        n         = 0;
        while (wbm_stb_o && n < 100) begin
            stb_n++;
            check("bus_cyc", {31'b0, wbm_cyc_o}, 32'h1);
            check("bus_we", {31'b0, wbm_we_o}, {31'b0, we});
            check("bus_adr", wbm_adr_o, adr);
            check("bus_dat", wbm_dat_o, dat);
            check("bus_sel", {28'b0, wbm_sel_o}, {28'b0, sel});
            check("bus_cmd_ready", {31'b0, cmd_ready}, 32'h0);
            if (stb_n == ack_dly + 1) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = rdata;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = $urandom;
            end
            @(negedge clk);
            n++;
        end
        wbm_ack_i = 1'b0;
        if (wbm_stb_o) begin
            check("stb_bound", {31'b0, wbm_stb_o}, 32'h0);
            return;
        end
        check("cyc_drop", {31'b0, wbm_cyc_o}, 32'h0);
        check("rsp_valid_rise", {31'b0, rsp_valid}, 32'h1);
        err  = rsp_err;
        rdat = rsp_dat;
        for (int i = 0; i < rsp_dly; i++) begin
            rsp_ready = 1'b0;
            wbm_ack_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_valid", {31'b0, rsp_valid}, 32'h1);
            check("hold_dat", rsp_dat, rdat);
            check("hold_err", {31'b0, rsp_err}, {31'b0, err});
            check("hold_cmd_ready", {31'b0, cmd_ready}, 32'h0);
            check("hold_cyc", {31'b0, wbm_cyc_o}, 32'h0);
        end
        rsp_ready = 1'b1;
        wbm_ack_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0;
        check("rsp_valid_fall", {31'b0, rsp_valid}, 32'h0);
        check("cmd_ready_back", {31'b0, cmd_ready}, 32'h1);
        check("idle_cyc", {31'b0, wbm_cyc_o}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          stb_n, exp_stb;
        logic        err, exp_err;
        logic [31:0] rdat, exp_dat;
        logic        we;
        int          ack_dly;
        logic [31:0] rdata;

        vecs[0] = '{1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF, 0, 32'hDEAD_BEEF, 0,
                    1, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b0, 32'h3800_0040, 32'h0, 4'hF, 3, 32'h0000_00AB, 1,
                    4, 1'b0, 32'h0000_00AB};
        vecs[2] = '{1'b0, 32'h3000_0020, 32'h0, 4'hF, NEVER, 32'h1111_2222, 2,
                    16, 1'b1, 32'hFFFF_FFFF};
        vecs[3] = '{1'b0, 32'h3800_0000, 32'h0, 4'hF, 1, 32'h5A5A_0001, 5,
                    2, 1'b0, 32'h5A5A_0001};
        vecs[4] = '{1'b0, 32'h3000_0004, 32'h0, 4'h3, 15, 32'hCAFE_0015, 0,
                    16, 1'b0, 32'hCAFE_0015};
        vecs[5] = '{1'b1, 32'h3000_0008, 32'hAAAA_5555, 4'hC, 16, 32'hCAFE_0016, 1,
                    16, 1'b1, 32'hFFFF_FFFF};
        vecs[6] = '{1'b1, 32'h3800_0100, 32'h0BAD_F00D, 4'h1, 2, 32'h7777_7777, 0,
                    3, 1'b0, 32'h0000_0000};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h0;
        cmd_dat   = 32'h0;
        cmd_sel   = 4'h0;
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = 32'h0;

        // Reset state
        #2;
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        check("rst_rsp_dat", rsp_dat, 32'h0);
        check("rst_cyc", {31'b0, wbm_cyc_o}, 32'h0);
        check("rst_stb", {31'b0, wbm_stb_o}, 32'h0);
        check("rst_we", {31'b0, wbm_we_o}, 32'h0);
        check("rst_sel", {28'b0, wbm_sel_o}, 32'h0);
        check("rst_adr", wbm_adr_o, 32'h0);
        check("rst_dat", wbm_dat_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("release_cmd_ready_low", {31'b0, cmd_ready}, 32'h0);
        @(negedge clk);
        check("release_cmd_ready_high", {31'b0, cmd_ready}, 32'h1);

        // Ack while idle must be ignored
        wbm_ack_i = 1'b1;
        repeat (2) @(negedge clk);
        wbm_ack_i = 1'b0;
        check("idle_ack_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("idle_ack_cyc", {31'b0, wbm_cyc_o}, 32'h0);
        check("idle_ack_cmd_ready", {31'b0, cmd_ready}, 32'h1);

        // Directed vector table
        for (int v = 0; v < 7; v++) begin
            run_txn(vecs[v].we, vecs[v].adr, vecs[v].dat, vecs[v].sel, vecs[v].ack_dly,
                    vecs[v].rdata, vecs[v].rsp_dly, stb_n, err, rdat);
            check($sformatf("vec%0d_stb_cycles", v), stb_n, vecs[v].exp_stb);
            check($sformatf("vec%0d_rsp_err", v), {31'b0, err}, {31'b0, vecs[v].exp_err});
            check($sformatf("vec%0d_rsp_dat", v), rdat, vecs[v].exp_dat);
        end

        // Reset while a bus cycle is in flight
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0030;
        cmd_sel   = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        check("midbus_cyc_before", {31'b0, wbm_cyc_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("midbus_cyc_async", {31'b0, wbm_cyc_o}, 32'h0);
        check("midbus_stb_async", {31'b0, wbm_stb_o}, 32'h0);
        check("midbus_rsp_valid_async", {31'b0, rsp_valid}, 32'h0);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h5151_5151;
        repeat (2) @(negedge clk);
        wbm_ack_i = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("midbus_release_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("midbus_no_stale_rsp", {31'b0, rsp_valid}, 32'h0);
            check("midbus_no_cyc", {31'b0, wbm_cyc_o}, 32'h0);
            @(negedge clk);
        end

`ifdef WBM_SEQ_ERR_EN
        // Error and ack together: error wins
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0000;
        cmd_sel   = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("err_stb", {31'b0, wbm_stb_o}, 32'h1);
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
        wbm_dat_i = 32'h0000_1234;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        check("err_cyc_drop", {31'b0, wbm_cyc_o}, 32'h0);
        check("err_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        check("err_rsp_err", {31'b0, rsp_err}, 32'h1);
        check("err_rsp_dat", rsp_dat, 32'hFFFF_FFFF);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("err_rsp_done", {31'b0, rsp_valid}, 32'h0);
`endif

        // Random traffic against the reference model
        for (int t = 0; t < 40; t++) begin
            we      = 1'($urandom);
            ack_dly = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 19));
            rdata   = $urandom;
            model(we, ack_dly, rdata, exp_stb, exp_err, exp_dat);
            run_txn(we, 32'h3000_0000 | ($urandom & 32'h08FF_FFFC), $urandom, 4'($urandom),
                    ack_dly, rdata, int'($urandom_range(0, 3)), stb_n, err, rdat);
            check($sformatf("rnd%0d_stb_cycles", t), stb_n, exp_stb);
            check($sformatf("rnd%0d_rsp_err", t), {31'b0, err}, {31'b0, exp_err});
            check($sformatf("rnd%0d_rsp_dat", t), rdat, exp_dat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_master_seq.md
Name: wb_master_seq

Overview:
Single-transfer Wishbone classic initiator. It accepts read/write commands on a valid/ready command port and drives one Wishbone cycle per command toward the user-area slave decoder (0x3000_0000 bridge and 0x3800_0000 FIR windows). It returns read data and status on a valid/ready response port. It is the bus-master counterpart used by on-chip sequencers and test engines to exercise the user-project slaves without the management core.

Parameters:
- ADDR_W, 32, Wishbone address width
- DATA_W, 32, Wishbone data width
- TIMEOUT, 16, maximum cycles to wait for ack; 0 disables the timeout
- TO_DATA, 32'hFFFF_FFFF, rsp_dat value returned on timeout or error

Ports:
- wb_clk_i  in  1  clock
- wb_rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  ADDR_W  byte address
- cmd_dat  in  DATA_W  write data
- cmd_sel  in  4  byte selects
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_dat  out  DATA_W  read data (0 for writes)
- rsp_err  out  1  1 = timeout or bus error
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  byte selects
- wbm_adr_o  out  ADDR_W  address
- wbm_dat_o  out  DATA_W  write data
- wbm_ack_i  in  1  slave acknowledge
- wbm_dat_i  in  DATA_W  slave read data

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_n is asynchronous and active-low.
- Reset values: all outputs are registered and clear to 0, including cmd_ready, rsp_valid, rsp_err, rsp_dat, and all wbm_* outputs. On reset release the FSM enters IDLE. cmd_ready rises on the first clock edge after reset deassertion.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready at edge N: latch we/adr/dat/sel onto the wbm_* outputs, set cyc=stb=1, cmd_ready=0, clear the timeout counter, go to BUS.
  - wbm_cyc_o is visible from edge N.
- BUS:
  - cyc/stb and all wbm_* outputs are held stable.
  - The counter increments every cycle that ack is low.
  - ack sampled high at an edge:
    - cyc=stb=0 at that same edge.
    - rsp_dat = wbm_dat_i for a read, 0 for a write.
    - rsp_err=0, rsp_valid=1, go to RESP.
  - Timeout: TIMEOUT≠0 and the counter reaches TIMEOUT-1 with ack low → cyc=stb=0, rsp_dat=TO_DATA, rsp_err=1, rsp_valid=1, go to RESP.
  - ack and timeout on the same edge: ack wins.
- RESP:
  - rsp_valid, rsp_dat and rsp_err are held until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid=0, cmd_ready=1, go to IDLE.
  - The next command is accepted no earlier than one cycle after the response handshake. At most one transaction is outstanding.
- Latency: with a zero-wait slave (ack in the first stb cycle), command accept at edge N gives rsp_valid at edge N+1.
- wbm_ack_i seen outside BUS is ignored (no state change, no response).
- Counter width: clog2(TIMEOUT+1), saturating. With TIMEOUT=0 the master waits for ack indefinitely.
- Reset mid-cycle: cyc/stb drop immediately (asynchronously), the in-flight response is discarded, and the FSM returns to IDLE.
- wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o keep their last values while cyc=0; slaves must not decode them.

Optional Feature:
- Macro: WBM_SEQ_ERR_EN.
- Defined:
  - Adds input port wbm_err_i (1 bit).
  - In BUS, err sampled high is handled like ack (cycle terminated the same edge) but gives rsp_err=1 and rsp_dat=TO_DATA.
  - ack and err on the same edge: err wins.
  - err outside BUS is ignored.
- Undefined: the port is absent and only a timeout can produce rsp_err=1.

Test Plan:
- Zero-wait write: cmd we=1, adr=0x3000_0010, dat=0x1234_5678, sel=0xF, accepted at edge N. Expect:
  - cyc/stb/we high after N with adr and dat driven.
  - Slave acks, giving rsp_valid=1, rsp_err=0, rsp_dat=0 at edge N+1.
  - cyc low at edge N+1.
- Wait-state read: cmd we=0, adr=0x3800_0040; slave acks 3 cycles late with dat 0x0000_00AB. Expect:
  - stb held for 4 cycles.
  - rsp_dat=0x0000_00AB, rsp_err=0.
- Timeout: TIMEOUT=16 and no ack. Expect:
  - cyc drops after exactly 16 cycles of stb.
  - rsp_err=1, rsp_dat=0xFFFF_FFFF.
  - An ack arriving afterwards is ignored.
- Response backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid. Expect:
  - rsp_valid, rsp_dat and rsp_err stable.
  - cmd_ready=0 throughout.
  - cmd_ready=1 on the edge after the handshake.
- Reset during BUS: assert wb_rst_n low 2 cycles after accept. Expect:
  - cyc/stb/rsp_valid go to 0 immediately.
  - After release, cmd_ready=1 and no stale response appears.
- Error (WBM_SEQ_ERR_EN defined): err and ack asserted together on a read of 0x3000_0000. Expect rsp_err=1 and rsp_dat=0xFFFF_FFFF.
